// File: rtl/rle_pkg.sv
// Shared definitions for the state run-length path (run counter and expander).
// Holds default field widths, the expander state encoding and the run-length
// decode helper. Widths here must stay in step with the run counter.
package rle_pkg;

  localparam int unsigned RLE_SYM_W = 2;
  localparam int unsigned RLE_LEN_W = 3;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } rle_state_e;

  // A length field of zero stands for the largest run, 2**len_w.
  function automatic int unsigned decode_len(input int unsigned len,
                                             input int unsigned len_w);
    return (len == 0) ? (32'd1 << len_w) : len;
  endfunction

endpackage

// File: rtl/run_length_expander.sv
// run_length_expander: replays each accepted (symbol, run length) pair on the
// output stream for exactly that many beats. Back-to-back pairs expand with no
// bubble cycles between runs.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   upstream pair valid
//   in_ready   a pair can be accepted this cycle
//   in_sym     symbol to replay
//   in_len     run length, 0 encodes 2**LEN_W
//   out_valid  out_sym valid this cycle
//   out_ready  downstream accepts the beat
//   out_sym    replayed symbol
//   out_last   final beat of the current run
//   busy       a run is in progress
//   runs_done  completed-run counter, wraps modulo 2**CNT_W
module run_length_expander
  import rle_pkg::*;
#(
  parameter int unsigned SYM_W = RLE_SYM_W,
  parameter int unsigned LEN_W = RLE_LEN_W,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SYM_W-1:0] in_sym,
  input  logic [LEN_W-1:0] in_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SYM_W-1:0] out_sym,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] runs_done
);

  // One extra bit so that 2**LEN_W itself is representable.
  localparam int unsigned REM_W = LEN_W + 1;

  rle_state_e       state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [SYM_W-1:0] sym_q, sym_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             in_fire;
  logic             out_fire;
  logic             rem_one;
  logic [REM_W-1:0] rem_load;

  assign rem_one  = (rem_q == REM_W'(1));
  assign rem_load = REM_W'(decode_len(32'(in_len), LEN_W));

  // in_ready depends combinationally on out_ready so that a new pair can be
  // taken on the final beat of the current run without a bubble.
  assign in_ready = (state_q == IDLE) ||
                    ((state_q == EXPAND) && rem_one && out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  assign out_valid = (state_q == EXPAND);
  assign busy      = (state_q == EXPAND);
  assign out_sym   = sym_q;
  assign out_last  = (state_q == EXPAND) && rem_one;
  assign runs_done = cnt_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    sym_d   = sym_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_fire) begin
          sym_d   = in_sym;
          rem_d   = rem_load;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        if (out_fire) begin
          if (!rem_one) begin
            rem_d = rem_q - REM_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (in_fire) begin
              sym_d = in_sym;
              rem_d = rem_load;
            end else begin
              rem_d   = '0;
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      sym_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sym_q   <= sym_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_run_length_expander.sv
module tb_run_length_expander;

  typedef struct {
    logic [1:0] sym;
    logic       last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_sym = '0;
  logic [2:0] in_len = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [1:0] out_sym;
  logic       out_last;
  logic       busy;
  logic [7:0] runs_done;

  int errors = 0;
  int checks = 0;

  beat_t expq[$];
  bit    rdy_pat[$];
  bit    rnd_mode = 0;
  int    model_runs = 0;
  int    beats = 0;
  bit    stall_hold = 0;
  logic [1:0] held_sym;
  logic       held_last;

  run_length_expander #(.SYM_W(2), .LEN_W(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym), .in_len(in_len),
    .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym),
    .out_last(out_last), .busy(busy), .runs_done(runs_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream readiness: explicit pattern first, else random or always-ready.
  always @(posedge clk) begin
    #1;
    if (rdy_pat.size() != 0) out_ready = rdy_pat.pop_front();
    else if (rnd_mode)       out_ready = ($urandom % 4) != 0;
    else                     out_ready = 1'b1;
  end

  // Monitor/scoreboard: handshake values are stable from here to the next
  // rising edge, so fires seen now are the ones that edge will commit.
  always @(negedge clk) begin
    if (rst) begin
      expq.delete();
      model_runs = 0;
      stall_hold = 0;
    end else begin
      chk("out_valid", out_valid, expq.size() != 0);
      chk("busy", busy, expq.size() != 0);
      chk("runs_done", runs_done, model_runs % 256);
      chk("in_ready", in_ready, (expq.size() == 0) || (out_ready && expq[0].last));
      if (stall_hold) begin
        chk("stall_sym", out_sym, held_sym);
        chk("stall_last", out_last, held_last);
      end
      if (out_valid && expq.size() != 0) begin
        chk("out_sym", out_sym, expq[0].sym);
        chk("out_last", out_last, expq[0].last);
        if (out_ready) begin
          beat_t b;
          b = expq.pop_front();
          beats++;
          if (b.last) model_runs++;
        end
      end
      stall_hold = out_valid && !out_ready;
      held_sym   = out_sym;
      held_last  = out_last;
      if (in_valid && in_ready) begin
        int n;
        n = (in_len == 0) ? 8 : int'(in_len);
        for (int k = 1; k <= n; k++) expq.push_back('{sym: in_sym, last: (k == n)});
      end
    end
  end

  // Caller is 1 time unit after a rising edge. Returns 1 unit after the fire edge.
  task automatic send(input logic [1:0] s, input logic [2:0] l, input bit hold);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_sym   = s;
    in_len   = l;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (expq.size() == 0 && !out_valid) begin ok = 1; break; end
    end
    if (!ok) chk("drain_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int b0;
    bit ok;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_runs_done", runs_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_sym", out_sym, 0);
    chk("rst_out_last", out_last, 0);
    @(posedge clk); #1;

    // Basic run
    b0 = beats;
    send(2'd2, 3'd3, 0);
    drain();
    chk("basic_beats", beats - b0, 3);
    chk("basic_runs", runs_done, 1);

    // Zero-length encodes 8
    b0 = beats;
    send(2'd1, 3'd0, 0);
    drain();
    chk("len0_beats", beats - b0, 8);

    // Back-to-back, in_valid held high
    b0 = beats;
    send(2'd3, 3'd1, 1);
    send(2'd0, 3'd2, 1);
    send(2'd1, 3'd1, 0);
    drain();
    chk("b2b_beats", beats - b0, 4);
    chk("b2b_runs", runs_done, 5);

    // Backpressure pattern 1,0,0,1,1,0,1
    b0 = beats;
    in_valid = 1'b1; in_sym = 2'd2; in_len = 3'd4;
    @(negedge clk);
    chk("bp_in_ready", in_ready, 1);
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
    chk("bp_beats", beats - b0, 4);

    // Reset mid-run after 2 accepted beats
    b0 = beats;
    send(2'd3, 3'd5, 0);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (beats - b0 >= 2) begin ok = 1; break; end
    end
    if (!ok) chk("midrun_timeout", 0, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrun_out_valid", out_valid, 0);
    chk("midrun_runs_done", runs_done, 0);
    chk("midrun_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    send(2'd1, 3'd2, 0);
    drain();
    chk("post_rst_runs", runs_done, 1);

    // Wrap of runs_done
    do_reset();
    rnd_mode = 1;
    for (int i = 0; i < 256; i++) send(2'd0, 3'd1, i != 255);
    drain();
    chk("wrap_zero", runs_done, 0);
    send(2'd0, 3'd1, 0);
    drain();
    chk("wrap_one", runs_done, 1);

    // Random pairs with random gaps and backpressure
    for (int i = 0; i < 60; i++) begin
      send(2'($urandom), 3'($urandom), ($urandom % 2) == 1);
      if (!in_valid) repeat ($urandom % 3) begin @(posedge clk); #1; end
    end
    in_valid = 1'b0;
    drain();
    chk("rand_runs", runs_done, model_runs % 256);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
